// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle adder/subtractor. Operands are consumed one SLICE-bit chunk per clock
// with the inter-slice carry held in a register; results and flags update atomically on done.
module seq_add_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z
);

   localparam int unsigned N    = WIDTH / SLICE;
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

   if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_params
      $error("seq_add_sub: WIDTH must be a non-zero multiple of SLICE");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, part_q;
   logic             carry_q;
   logic [IdxW-1:0]  idx_q;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q, v_q, z_q;

   logic [SLICE-1:0] a_slice, b_slice, sum_slice;
   logic             slice_cout, msb_cin;
   logic [WIDTH-1:0] part_d;

   // Current slice add; part_d is the partial sum with this slice merged in.
   always_comb begin
      a_slice = a_q[32'(idx_q) * SLICE +: SLICE];
      b_slice = b_q[32'(idx_q) * SLICE +: SLICE];
      {slice_cout, sum_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
      // Carry into the slice MSB recovered from the sum bit; only meaningful on the last slice.
      msb_cin = sum_slice[SLICE-1] ^ a_slice[SLICE-1] ^ b_slice[SLICE-1];
      part_d = part_q;
      part_d[32'(idx_q) * SLICE +: SLICE] = sum_slice;
   end

   // Control FSM and all datapath/result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= A;
                  // Subtract as A + ~B + 1; Cin is ignored in that mode.
                  b_q     <= op ? ~B : B;
                  carry_q <= op | Cin;
                  part_q  <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               part_q  <= part_d;
               carry_q <= slice_cout;
               idx_q   <= idx_q + IdxW'(1);
               if (idx_q == LastIdx) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  s_q     <= part_d;
                  cout_q  <= slice_cout;
                  v_q     <= msb_cin ^ slice_cout;
                  z_q     <= (part_d == '0);
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;
   assign V    = v_q;
   assign Z    = z_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: an 8-bit/4-bit-slice instance and a 16-bit bit-serial one.
module tb_seq_add_sub;

   localparam int unsigned W0 = 8;
   localparam int unsigned S0 = 4;
   localparam int unsigned N0 = W0 / S0;
   localparam int unsigned W1 = 16;
   localparam int unsigned S1 = 1;
   localparam int unsigned N1 = W1 / S1;

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        v;
      logic        z;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic          start0, op0, cin0, busy0, done0, cout0, v0, z0;
   logic [W0-1:0] a0, b0, s0;
   logic          start1, op1, cin1, busy1, done1, cout1, v1, z1;
   logic [W1-1:0] a1, b1, s1;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t hold0, hold1;
   logic prev_done0 = 1'b0, prev_done1 = 1'b0;

   seq_add_sub #(.WIDTH(W0), .SLICE(S0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .op(op0), .A(a0), .B(b0), .Cin(cin0),
      .busy(busy0), .done(done0), .S(s0), .Cout(cout0), .V(v0), .Z(z0)
   );

   seq_add_sub #(.WIDTH(W1), .SLICE(S1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .op(op1), .A(a1), .B(b1), .Cin(cin1),
      .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1), .Z(z1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic note_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Reference: plain integer arithmetic and two's-complement sign rules.
   function automatic exp_t model(input int unsigned w, input logic o, input logic [31:0] a,
                                  input logic [31:0] b, input logic c);
      exp_t        e;
      logic [32:0] full;
      logic [31:0] mask;
      logic        sa, sb, ss;
      mask = 32'((33'd1 << w) - 33'd1);
      if (o) begin
         e.s    = (a - b) & mask;
         e.cout = (a >= b);
      end else begin
         full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
         e.s    = full[31:0] & mask;
         e.cout = full[w];
      end
      sa  = a[w-1];
      sb  = b[w-1];
      ss  = e.s[w-1];
      e.v = o ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      e.z = (e.s == 32'd0);
      return e;
   endfunction

   // Monitor for the 8-bit instance: pop on done, check result hold while busy.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q0.delete();
         hold0.s = '0; hold0.cout = 1'b0; hold0.v = 1'b0; hold0.z = 1'b0;
      end else if (done0) begin
         if (prev_done0) note_fail("dut0 done wider than one cycle");
         if (q0.size() == 0) begin
            note_fail("dut0 done with empty scoreboard");
         end else begin
            e = q0.pop_front();
            chk("dut0 S", 32'(s0), e.s);
            chk("dut0 Cout", 32'(cout0), 32'(e.cout));
            chk("dut0 V", 32'(v0), 32'(e.v));
            chk("dut0 Z", 32'(z0), 32'(e.z));
            hold0 = e;
         end
      end else if (busy0) begin
         chk("dut0 S hold during run", 32'(s0), hold0.s);
         chk("dut0 Z hold during run", 32'(z0), 32'(hold0.z));
      end
      prev_done0 = done0;
   end

   // Monitor for the 16-bit bit-serial instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q1.delete();
         hold1.s = '0; hold1.cout = 1'b0; hold1.v = 1'b0; hold1.z = 1'b0;
      end else if (done1) begin
         if (prev_done1) note_fail("dut1 done wider than one cycle");
         if (q1.size() == 0) begin
            note_fail("dut1 done with empty scoreboard");
         end else begin
            e = q1.pop_front();
            chk("dut1 S", 32'(s1), e.s);
            chk("dut1 Cout", 32'(cout1), 32'(e.cout));
            chk("dut1 V", 32'(v1), 32'(e.v));
            chk("dut1 Z", 32'(z1), 32'(e.z));
            hold1 = e;
         end
      end else if (busy1) begin
         chk("dut1 S hold during run", 32'(s1), hold1.s);
      end
      prev_done1 = done1;
   end

   // One operation on instance sel; optionally scramble inputs right after acceptance.
   task automatic run_op(input int sel, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input bit scramble);
      exp_t e;
      int   busy_cnt, t, n;
      e = model(sel == 0 ? W0 : W1, o, a, b, c);
      n = (sel == 0) ? int'(N0) : int'(N1);
      @(negedge clk);
      if (sel == 0) begin
         op0 = o; a0 = a[W0-1:0]; b0 = b[W0-1:0]; cin0 = c; start0 = 1'b1;
         q0.push_back(e);
      end else begin
         op1 = o; a1 = a[W1-1:0]; b1 = b[W1-1:0]; cin1 = c; start1 = 1'b1;
         q1.push_back(e);
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (scramble) begin
         a0 = W0'($urandom); b0 = W0'($urandom); op0 = 1'($urandom); cin0 = 1'($urandom);
         a1 = W1'($urandom); b1 = W1'($urandom); op1 = 1'($urandom); cin1 = 1'($urandom);
      end
      busy_cnt = 0;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         if ((sel == 0) ? done0 : done1) break;
         if ((sel == 0) ? busy0 : busy1) busy_cnt++;
      end
      chk($sformatf("dut%0d done within budget", sel), (t < 200) ? 1 : 0, 1);
      chk($sformatf("dut%0d busy cycle count", sel), busy_cnt, n);
      chk($sformatf("dut%0d busy low with done", sel), (sel == 0) ? 32'(busy0) : 32'(busy1), 0);
   endtask

   // Start held high: three operations back to back, spaced by IDLE+RUN*N+DONE.
   task automatic held_start();
      exp_t        e;
      int unsigned dcyc[$];
      logic [7:0]  a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      e = model(W0, 1'b0, 32'(a), 32'(b), 1'b0);
      @(negedge clk);
      op0 = 1'b0; a0 = a; b0 = b; cin0 = 1'b0; start0 = 1'b1;
      repeat (3) q0.push_back(e);
      for (int t = 0; t < 100 && dcyc.size() < 3; t++) begin
         @(negedge clk);
         if (done0) dcyc.push_back(cyc);
      end
      start0 = 1'b0;
      chk("held start done count", dcyc.size(), 3);
      if (dcyc.size() == 3) begin
         chk("held start spacing 1", dcyc[1] - dcyc[0], N0 + 2);
         chk("held start spacing 2", dcyc[2] - dcyc[1], N0 + 2);
      end
      repeat (N0 + 4) @(negedge clk);
      chk("held start scoreboard drained", q0.size(), 0);
   endtask

   // Reset between edges k+1 and k+2 of an operation.
   task automatic reset_mid_run();
      int extra;
      @(negedge clk);
      op0 = 1'b0; a0 = 8'h21; b0 = 8'h43; cin0 = 1'b1; start0 = 1'b1;
      q0.push_back(model(W0, 1'b0, 32'h21, 32'h43, 1'b1));
      @(posedge clk);
      #1 start0 = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid-run reset busy", 32'(busy0), 0);
      chk("mid-run reset done", 32'(done0), 0);
      chk("mid-run reset S", 32'(s0), 0);
      chk("mid-run reset Cout", 32'(cout0), 0);
      chk("mid-run reset V", 32'(v0), 0);
      chk("mid-run reset Z", 32'(z0), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (N0 + 4) begin
         @(negedge clk);
         if (done0) extra++;
      end
      chk("no done after mid-run reset", extra, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "tb_seq_add_sub: time limit");
   end

   initial begin
      rst = 1'b1;
      start0 = 1'b0; op0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
      start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy0", 32'(busy0), 0);
      chk("reset done0", 32'(done0), 0);
      chk("reset S0", 32'(s0), 0);
      chk("reset Cout0/V0/Z0", {29'd0, cout0, v0, z0}, 0);
      chk("reset busy1/done1", {30'd0, busy1, done1}, 0);
      chk("reset S1", 32'(s1), 0);
      rst = 1'b0;

      run_op(0, 1'b0, 32'hFF, 32'h01, 1'b0, 1'b0);
      run_op(0, 1'b1, 32'h80, 32'h01, 1'b0, 1'b0);
      run_op(0, 1'b1, 32'h05, 32'h07, 1'b1, 1'b0);
      run_op(0, 1'b0, 32'h7F, 32'h00, 1'b1, 1'b1);
      run_op(0, 1'b1, 32'h5A, 32'h5A, 1'b0, 1'b0);
      run_op(0, 1'b0, 32'h80, 32'h80, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) begin
         run_op(0, 1'($urandom), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom));
      end

      held_start();

      run_op(0, 1'b0, 32'h12, 32'h34, 1'b0, 1'b0);
      reset_mid_run();
      run_op(0, 1'b0, 32'h3C, 32'h0F, 1'b1, 1'b0);

      run_op(1, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      run_op(1, 1'b1, 32'h8000, 32'h0001, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run_op(1, 1'($urandom), 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                1'($urandom), 1'($urandom));
      end

      repeat (4) @(negedge clk);
      chk("dut0 scoreboard empty at end", q0.size(), 0);
      chk("dut1 scoreboard empty at end", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
